// File: rtl/taxi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | taxi_pkg : shared state encodings, default tariff and datapath width     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package taxi_pkg;
   localparam int DW = 16;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] HIRED   = 3'd1;
   localparam logic [2:0] STOPPED = 3'd2;
   localparam logic [2:0] FREEZE  = 3'd3;
   localparam logic [2:0] SETTLE  = 3'd4;

   localparam int DEF_INIT    = 10;
   localparam int DEF_PER     = 2;
   localparam int DEF_ADDMILE = 7;
endpackage
`default_nettype wire

// File: rtl/taxi_wheel_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | taxi_wheel_sync : wheel synchroniser, edge detect, pulse-to-km divider   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module taxi_wheel_sync
   import taxi_pkg::*;
#(
   parameter int PULSES_PER_KM = 100
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wheel_raw,
   input  logic          count_en,
   input  logic          clear,
   output logic          wpulse,
   output logic [DW-1:0] distance
);
   localparam int            CW      = (PULSES_PER_KM > 1) ? $clog2(PULSES_PER_KM) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(PULSES_PER_KM - 1);

   logic          sync1, sync2, sync_prev, pulse_r;
   logic [CW-1:0] cnt_r, cnt_nxt;
   logic [DW-1:0] dist_r, dist_nxt;

   always_comb begin
      cnt_nxt  = cnt_r;
      dist_nxt = dist_r;
      if (clear) begin
         cnt_nxt  = '0;
         dist_nxt = '0;
      end else if (count_en && pulse_r) begin
         if (cnt_r == CNT_MAX) begin
            cnt_nxt = '0;
            // distance saturates rather than wrapping back to zero
            if (dist_r != '1)
               dist_nxt = dist_r + 16'd1;
         end else begin
            cnt_nxt = cnt_r + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         sync_prev <= 1'b0;
         pulse_r   <= 1'b0;
         cnt_r     <= '0;
         dist_r    <= '0;
      end else begin
         sync1     <= wheel_raw;
         sync2     <= sync1;
         sync_prev <= sync2;
         pulse_r   <= sync2 & ~sync_prev;
         cnt_r     <= cnt_nxt;
         dist_r    <= dist_nxt;
      end
   end

   assign wpulse   = pulse_r;
   assign distance = dist_r;
endmodule
`default_nettype wire

// File: rtl/taxi_trip_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | taxi_trip_ctrl : trip sequencer controlling the fare unit                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module taxi_trip_ctrl
   import taxi_pkg::*;
#(
   parameter int PULSES_PER_KM = 100,
   parameter int STOP_TICKS    = 1000,
   parameter int SETTLE_TICKS  = 5000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_req,
   input  logic          end_req,
   input  logic          wheel_raw,
   input  logic          cfg_load,
   input  logic [2:0]    cfg_init,
   input  logic [2:0]    cfg_per,
   input  logic [2:0]    cfg_addmile,
   input  logic [DW-1:0] fare_in,
   output logic [DW-1:0] distance,
   output logic          meter_clear,
   output logic          meter_set,
   output logic [2:0]    cfg_init_o,
   output logic [2:0]    cfg_per_o,
   output logic [2:0]    cfg_addmile_o,
   output logic [DW-1:0] fare_hold,
   output logic [2:0]    state_o,
   output logic          trip_done
);
   localparam int            SW       = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;
   localparam int            TW       = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
   localparam logic [SW-1:0] STOP_MAX = SW'(STOP_TICKS - 1);
   localparam logic [TW-1:0] SETL_MAX = TW'(SETTLE_TICKS - 1);

   logic [2:0]    state_r, state_nxt;
   logic [SW-1:0] stop_cnt;
   logic [TW-1:0] settle_cnt;
   logic          freeze_cnt;
   logic          wpulse;
   logic          dist_clear;
   logic          count_en;

   assign count_en = (state_r == HIRED) || (state_r == STOPPED);

   taxi_wheel_sync #(
      .PULSES_PER_KM (PULSES_PER_KM)
   ) u_wheel (
      .clk       (clk),
      .rst       (rst),
      .wheel_raw (wheel_raw),
      .count_en  (count_en),
      .clear     (dist_clear),
      .wpulse    (wpulse),
      .distance  (distance)
   );

   always_comb begin
      state_nxt  = state_r;
      dist_clear = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_req) begin
               state_nxt  = HIRED;
               dist_clear = 1'b1;
            end
         end
         HIRED: begin
            if (end_req)
               state_nxt = FREEZE;
            else if (!wpulse && stop_cnt == STOP_MAX)
               state_nxt = STOPPED;
         end
         STOPPED: begin
            if (end_req)
               state_nxt = FREEZE;
            else if (wpulse)
               state_nxt = HIRED;
         end
         FREEZE: begin
            if (freeze_cnt)
               state_nxt = SETTLE;
         end
         SETTLE: begin
            // a new hire overrides the settle timeout
            if (start_req) begin
               state_nxt  = HIRED;
               dist_clear = 1'b1;
            end else if (settle_cnt == SETL_MAX) begin
               state_nxt  = IDLE;
               dist_clear = 1'b1;
            end
         end
         default: begin
            state_nxt  = IDLE;
            dist_clear = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= IDLE;
         stop_cnt      <= '0;
         settle_cnt    <= '0;
         freeze_cnt    <= 1'b0;
         fare_hold     <= '0;
         trip_done     <= 1'b0;
         meter_set     <= 1'b0;
         cfg_init_o    <= '0;
         cfg_per_o     <= '0;
         cfg_addmile_o <= '0;
      end else begin
         state_r <= state_nxt;

         if (state_r == HIRED && state_nxt == HIRED && !wpulse)
            stop_cnt <= stop_cnt + 1'b1;
         else
            stop_cnt <= '0;

         if (state_r == SETTLE && state_nxt == SETTLE)
            settle_cnt <= settle_cnt + 1'b1;
         else
            settle_cnt <= '0;

         // two FREEZE cycles let the registered fare catch up with distance
         freeze_cnt <= (state_r == FREEZE) && !freeze_cnt;
         trip_done  <= (state_r == FREEZE) && freeze_cnt;
         if (state_r == FREEZE && freeze_cnt)
            fare_hold <= fare_in;

         if (state_r == IDLE && cfg_load) begin
            meter_set     <= 1'b1;
            cfg_init_o    <= cfg_init;
            cfg_per_o     <= cfg_per;
            cfg_addmile_o <= cfg_addmile;
         end
      end
   end

   assign meter_clear = (state_r == IDLE);
   assign state_o     = state_r;
endmodule
`default_nettype wire

// File: tb/tb_taxi_trip_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_taxi_trip_ctrl : directed self-checking bench for taxi_trip_ctrl      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_taxi_trip_ctrl;
   import taxi_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_req, end_req, wheel_raw, cfg_load;
   logic [2:0]    cfg_init, cfg_per, cfg_addmile;
   logic [15:0]   fare_in = '0;
   logic [15:0]   distance, fare_hold;
   logic          meter_clear, meter_set, trip_done;
   logic [2:0]    cfg_init_o, cfg_per_o, cfg_addmile_o, state_o;

   int n_cmp = 0;
   int n_bad = 0;

   taxi_trip_ctrl #(
      .PULSES_PER_KM (4),
      .STOP_TICKS    (8),
      .SETTLE_TICKS  (6)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_req     (start_req),
      .end_req       (end_req),
      .wheel_raw     (wheel_raw),
      .cfg_load      (cfg_load),
      .cfg_init      (cfg_init),
      .cfg_per       (cfg_per),
      .cfg_addmile   (cfg_addmile),
      .fare_in       (fare_in),
      .distance      (distance),
      .meter_clear   (meter_clear),
      .meter_set     (meter_set),
      .cfg_init_o    (cfg_init_o),
      .cfg_per_o     (cfg_per_o),
      .cfg_addmile_o (cfg_addmile_o),
      .fare_hold     (fare_hold),
      .state_o       (state_o),
      .trip_done     (trip_done)
   );

   always #5 clk = ~clk;

   // fare unit: start fare + per-km price, one extra per-km beyond the surcharge distance
   always_ff @(posedge clk)
      fare_in <= meter_clear ? 16'd0
               : 16'(DEF_INIT + DEF_PER * int'(distance)
                     + ((int'(distance) > DEF_ADDMILE) ? DEF_PER : 0));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wheel_edge();
      wheel_raw = 1'b1;
      tick();
      wheel_raw = 1'b0;
      tick();
      tick();
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; start_req = 1'b0; end_req = 1'b0; wheel_raw = 1'b0; cfg_load = 1'b0;
      cfg_init = 3'd0; cfg_per = 3'd0; cfg_addmile = 3'd0;
      tick(); tick();
      rst = 1'b1;
      check("rst_state", 16'(state_o), 16'd0);
      check("rst_dist", distance, 16'd0);
      check("rst_clear", 16'(meter_clear), 16'd1);
      check("rst_set", 16'(meter_set), 16'd0);
      check("rst_cfg", 16'({cfg_init_o, cfg_per_o, cfg_addmile_o}), 16'd0);
      check("rst_hold", fare_hold, 16'd0);
      check("rst_done", 16'(trip_done), 16'd0);

      // preset tariff latched in IDLE
      cfg_load = 1'b1; cfg_init = 3'd5; cfg_per = 3'd3; cfg_addmile = 3'd6;
      tick();
      cfg_load = 1'b0;
      check("cfg_set", 16'(meter_set), 16'd1);
      check("cfg_init", 16'(cfg_init_o), 16'd5);
      check("cfg_per", 16'(cfg_per_o), 16'd3);
      check("cfg_add", 16'(cfg_addmile_o), 16'd6);
      start_req = 1'b1; tick(); start_req = 1'b0;
      check("start_state", 16'(state_o), 16'd1);
      check("start_clear", 16'(meter_clear), 16'd0);
      cfg_load = 1'b1; cfg_init = 3'd1; cfg_per = 3'd1; cfg_addmile = 3'd1;
      tick();
      cfg_load = 1'b0;
      check("cfg_hired", 16'({cfg_init_o, cfg_per_o, cfg_addmile_o}), 16'({3'd5, 3'd3, 3'd6}));

      // 12 wheel edges at 4 pulses/km -> 3 km
      for (int i = 0; i < 12; i++) wheel_edge();
      tick();
      start_req = 1'b1; tick(); start_req = 1'b0;
      check("dist3", distance, 16'd3);
      check("start_ign", 16'(state_o), 16'd1);
      end_req = 1'b1; tick(); end_req = 1'b0;
      check("frz_state", 16'(state_o), 16'd3);
      check("frz_done0", 16'(trip_done), 16'd0);
      tick();
      check("frz_state2", 16'(state_o), 16'd3);
      tick();
      check("settle_state", 16'(state_o), 16'd4);
      check("done_pulse", 16'(trip_done), 16'd1);
      check("hold16", fare_hold, 16'd16);
      tick();
      check("done_low", 16'(trip_done), 16'd0);
      check("settle_dist", distance, 16'd3);
      for (int i = 0; i < 4; i++) tick();
      check("settle_last", 16'(state_o), 16'd4);
      tick();
      check("settle_idle", 16'(state_o), 16'd0);
      check("idle_clear", 16'(meter_clear), 16'd1);
      check("idle_dist", distance, 16'd0);
      check("idle_hold", fare_hold, 16'd16);

      // stationary detection and wake-up
      start_req = 1'b1; tick(); start_req = 1'b0;
      check("trip2_dist", distance, 16'd0);
      for (int i = 0; i < 5; i++) wheel_edge();
      tick();
      for (int i = 0; i < 7; i++) tick();
      check("not_stopped", 16'(state_o), 16'd1);
      tick();
      check("stopped", 16'(state_o), 16'd2);
      check("stop_dist", distance, 16'd1);
      wheel_edge();
      check("still_stop", 16'(state_o), 16'd2);
      tick();
      check("wake", 16'(state_o), 16'd1);
      wheel_edge();
      wheel_edge();
      end_req = 1'b1; tick(); end_req = 1'b0;
      check("end_pulse_cnt", distance, 16'd2);
      check("end_frz", 16'(state_o), 16'd3);
      tick(); tick();
      check("hold14", fare_hold, 16'd14);

      // new hire from SETTLE cycle 2
      tick();
      start_req = 1'b1; tick(); start_req = 1'b0;
      check("rehire_state", 16'(state_o), 16'd1);
      check("rehire_dist", distance, 16'd0);
      check("rehire_hold", fare_hold, 16'd14);

      // distance saturation
      force dut.u_wheel.dist_r = 16'hFFFE;
      tick();
      release dut.u_wheel.dist_r;
      check("preload", distance, 16'hFFFE);
      for (int i = 0; i < 8; i++) wheel_edge();
      tick();
      check("saturate", distance, 16'hFFFF);
      start_req = 1'b1; end_req = 1'b1; tick(); start_req = 1'b0; end_req = 1'b0;
      check("both_hired", 16'(state_o), 16'd3);
      check("both_dist", distance, 16'hFFFF);

      // reset in the middle of a trip
      tick(); tick();
      start_req = 1'b1; tick(); start_req = 1'b0;
      wheel_edge();
      rst = 1'b0; tick(); tick(); rst = 1'b1;
      check("mid_state", 16'(state_o), 16'd0);
      check("mid_dist", distance, 16'd0);
      check("mid_clear", 16'(meter_clear), 16'd1);
      check("mid_hold", fare_hold, 16'd0);
      check("mid_done", 16'(trip_done), 16'd0);
      check("mid_set", 16'(meter_set), 16'd0);
      end_req = 1'b1; tick(); end_req = 1'b0;
      check("end_idle", 16'(state_o), 16'd0);
      start_req = 1'b1; end_req = 1'b1; tick(); start_req = 1'b0; end_req = 1'b0;
      check("both_idle", 16'(state_o), 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
